// File: rtl/xnor_descrambler.sv
// Serial XNOR descrambler: LFSR-keyed bit descrambling, bytes assembled LSB first.
// Optional macro PARITY_CHECK_EN adds a scrambled even-parity 9th bit per byte and drives out_err.
module xnor_descrambler #(
    parameter logic [7:0] SEED = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_err
);

`ifdef PARITY_CHECK_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    typedef enum logic {SHIFT, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [3:0] bit_cnt;
    logic [7:0] acc;
    logic       accept;
    logic       last_bit;
    logic       dbit;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic descramble(input logic b, input logic key);
        return ~(b ^ key);
    endfunction

    assign accept   = in_valid & in_ready & ~sync;
    assign last_bit = (bit_cnt == LAST_BIT);
    assign dbit     = descramble(in_bit, lfsr[7]);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            SHIFT: begin
                in_ready = 1'b1;
                if (accept && last_bit)
                    state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = SHIFT;
            end
            default: state_nxt = SHIFT;
        endcase
    end

    // Sync only restarts the keystream and bit position; a held byte survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SHIFT;
            lfsr     <= SEED;
            bit_cnt  <= 4'd0;
            out_data <= 8'h00;
        end else begin
            state <= state_nxt;
            if (sync) begin
                lfsr    <= SEED;
                bit_cnt <= 4'd0;
            end else if (accept) begin
                lfsr    <= lfsr_step(lfsr);
                bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                if (last_bit) begin
`ifdef PARITY_CHECK_EN
                    out_data <= acc;
`else
                    out_data <= {dbit, acc[6:0]};
`endif
                end
            end
        end
    end

    // Partial-byte storage needs no reset: every bit is rewritten before a byte is emitted.
    always_ff @(posedge clk) begin
        if (accept && (bit_cnt < 4'd8))
            acc[bit_cnt[2:0]] <= dbit;
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            out_err <= 1'b0;
        else if (!sync && accept && last_bit)
            out_err <= ^{acc, dbit};
    end
`else
    assign out_err = 1'b0;
`endif

endmodule
